// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states and
// op-class decode helpers used by the top and the divider.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MUL   = 4'd1,
    OP_MULT  = 4'd2,
    OP_MULTU = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_DIV   = 4'd8,
    OP_DIVU  = 4'd9
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_ITER = 2'd1,
    DV_FIX  = 2'd2
  } div_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_op = 1'b1;
      default: is_mul_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    case (op)
      OP_DIV, OP_DIVU: is_div_op = 1'b1;
      default: is_div_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MULT, OP_MADD, OP_MSUB, OP_DIV: is_signed_op = 1'b1;
      default: is_signed_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    case (op)
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_acc_op = 1'b1;
      default: is_acc_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    case (op)
      OP_MSUB, OP_MSUBU: is_sub_op = 1'b1;
      default: is_sub_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider: DIV_BPC quotient bits per cycle on magnitudes,
// followed by one sign-fixup cycle; divide-by-zero short-circuits the loop.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DIV_BPC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div0
);

  localparam int ITERS = XLEN / DIV_BPC;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  div_state_e      st, st_n;
  logic [XLEN-1:0] q_r, rem_r, dvsr_r, dvnd_r;
  logic [CW-1:0]   cnt_r;
  logic            q_neg_r, r_neg_r, zero_r;
  logic [XLEN-1:0] q_step, rem_step;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] dvnd_abs, dvsr_abs;

  assign dvnd_abs = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
  assign dvsr_abs = (signed_op && divisor[XLEN-1]) ? -divisor : divisor;

  // q_r starts as the dividend magnitude and is shifted out MSB-first into
  // the partial remainder while quotient bits shift in at the bottom.
  always_comb begin
    q_step   = q_r;
    rem_step = rem_r;
    rem_sh   = '0;
    for (int i = 0; i < DIV_BPC; i++) begin
      rem_sh = {rem_step, q_step[XLEN-1]};
      q_step = {q_step[XLEN-2:0], 1'b0};
      if (rem_sh >= {1'b0, dvsr_r}) begin
        rem_sh    = rem_sh - {1'b0, dvsr_r};
        q_step[0] = 1'b1;
      end
      rem_step = rem_sh[XLEN-1:0];
    end
  end

  always_comb begin
    st_n = st;
    done = 1'b0;
    case (st)
      DV_IDLE: if (start) st_n = DV_ITER;
      DV_ITER: begin
        if (zero_r) begin
          done = 1'b1;
          st_n = DV_IDLE;
        end else if (cnt_r == LAST) begin
          st_n = DV_FIX;
        end
      end
      DV_FIX: begin
        done = 1'b1;
        st_n = DV_IDLE;
      end
      default: st_n = DV_IDLE;
    endcase
    if (abort) begin
      st_n = DV_IDLE;
      done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= DV_IDLE;
      cnt_r   <= '0;
      q_r     <= '0;
      rem_r   <= '0;
      dvsr_r  <= '0;
      dvnd_r  <= '0;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      zero_r  <= 1'b0;
    end else if (abort) begin
      st    <= DV_IDLE;
      cnt_r <= '0;
    end else begin
      st <= st_n;
      if (st == DV_IDLE && start) begin
        q_r     <= dvnd_abs;
        rem_r   <= '0;
        dvsr_r  <= dvsr_abs;
        dvnd_r  <= dividend;
        cnt_r   <= '0;
        q_neg_r <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        r_neg_r <= signed_op && dividend[XLEN-1];
        zero_r  <= (divisor == '0);
      end else if (st == DV_ITER && !zero_r) begin
        q_r   <= q_step;
        rem_r <= rem_step;
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign busy      = (st != DV_IDLE);
  assign div0      = zero_r;
  assign quotient  = zero_r ? '1 : (q_neg_r ? -q_r : q_r);
  assign remainder = zero_r ? dvnd_r : (r_neg_r ? -rem_r : rem_r);

endmodule

// File: rtl/mdu_iter.sv
// HI/LO-class multiply/divide unit: pipelined behavioural multiplier plus an
// iterative divider, one op in flight, result held until commit takes it.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3,
  parameter int DIV_BPC    = 1,
  parameter int ROB_W      = 4,
  parameter int PREG_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic [XLEN-1:0]   in_hi,
  input  logic [XLEN-1:0]   in_lo,
  input  logic [ROB_W-1:0]  in_rob1,
  input  logic [ROB_W-1:0]  in_rob2,
  input  logic [PREG_W-1:0] in_pd1,
  input  logic [PREG_W-1:0] in_pd2,
  input  logic              in_we1,
  input  logic              in_we2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_hi,
  output logic [XLEN-1:0]   out_lo,
  output logic [ROB_W-1:0]  out_rob1,
  output logic [ROB_W-1:0]  out_rob2,
  output logic [PREG_W-1:0] out_pd1,
  output logic [PREG_W-1:0] out_pd2,
  output logic              out_we1,
  output logic              out_we2,
  output logic              out_div0
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES);

  // Handshakes: a transfer happens on a clock edge where valid && ready are
  // both high; valid never depends on ready, and a producer holding valid
  // keeps its payload stable until the transfer.
  mdu_state_e        state, state_n;
  logic [2:0]        mul_cnt;
  logic              op_mul, op_div, accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] prod, acc, mul_res;
  logic [2*XLEN-1:0] pipe [MUL_STAGES];
  logic              div_busy, div_done, div_div0;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign op_mul    = is_mul_op(in_op);
  assign op_div    = is_div_op(in_op);
  assign in_ready  = !flush && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready && (op_mul || op_div);
  assign out_valid = (state == ST_DONE);

  // Full product formed at issue; the pipe registers behind it let synthesis
  // retime the multiplier across MUL_STAGES cycles.
  always_comb begin
    a_neg = is_signed_op(in_op) && in_src1[XLEN-1];
    b_neg = is_signed_op(in_op) && in_src2[XLEN-1];
    a_abs = a_neg ? -in_src1 : in_src1;
    b_abs = b_neg ? -in_src2 : in_src2;
    prod  = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
    if (a_neg ^ b_neg) prod = -prod;
    acc     = {in_hi, in_lo};
    mul_res = prod;
    if (is_acc_op(in_op)) mul_res = is_sub_op(in_op) ? (acc - prod) : (acc + prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else begin
      if (accept && op_mul) pipe[0] <= mul_res;
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  mdu_divider #(
    .XLEN    (XLEN),
    .DIV_BPC (DIV_BPC)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && op_div),
    .abort     (flush),
    .signed_op (is_signed_op(in_op)),
    .dividend  (in_src1),
    .divisor   (in_src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .div0      (div_div0)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = op_mul ? ST_MUL : ST_DIV;
      ST_MUL:  if (mul_cnt == MUL_LAST) state_n = ST_DONE;
      ST_DIV: begin
        if (div_done) state_n = ST_DONE;
        else if (!div_busy) state_n = ST_IDLE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_n = op_mul ? ST_MUL : ST_DIV;
          else state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      mul_cnt  <= '0;
      out_hi   <= '0;
      out_lo   <= '0;
      out_rob1 <= '0;
      out_rob2 <= '0;
      out_pd1  <= '0;
      out_pd2  <= '0;
      out_we1  <= 1'b0;
      out_we2  <= 1'b0;
      out_div0 <= 1'b0;
    end else begin
      state <= state_n;
      if (flush) mul_cnt <= '0;
      else if (accept) mul_cnt <= 3'd1;
      else if (state == ST_MUL) mul_cnt <= mul_cnt + 3'd1;
      // Tags can be loaded at issue: in_ready is low while a result is held.
      if (accept) begin
        out_rob1 <= in_rob1;
        out_rob2 <= in_rob2;
        out_pd1  <= in_pd1;
        out_pd2  <= in_pd2;
        out_we1  <= in_we1;
        out_we2  <= in_we2;
      end
      if (!flush && state == ST_MUL && mul_cnt == MUL_LAST) begin
        out_hi   <= pipe[MUL_STAGES-1][2*XLEN-1:XLEN];
        out_lo   <= pipe[MUL_STAGES-1][XLEN-1:0];
        out_div0 <= 1'b0;
      end
      if (!flush && state == ST_DIV && div_done) begin
        out_hi   <= div_rem;
        out_lo   <= div_quo;
        out_div0 <= div_div0;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed plus light random bench for mdu_iter with an expected-result queue.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int XLEN = 32, MUL_STAGES = 3, DIV_BPC = 1, ROB_W = 4, PREG_W = 6;
  localparam int MUL_LAT = MUL_STAGES + 1;
  localparam int DIV_LAT = XLEN / DIV_BPC + 2;
  localparam int TW = 2*ROB_W + 2*PREG_W + 2;
  localparam int W = 1 + TW + 2*XLEN;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_op;
  logic [XLEN-1:0] in_src1, in_src2, in_hi, in_lo, out_hi, out_lo;
  logic [ROB_W-1:0] in_rob1, in_rob2, out_rob1, out_rob2;
  logic [PREG_W-1:0] in_pd1, in_pd2, out_pd1, out_pd2;
  logic in_we1, in_we2, out_we1, out_we2, out_div0;

  logic [W-1:0] exp_q[$];
  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int seq = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_iter #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BPC(DIV_BPC),
             .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_hi(in_hi), .in_lo(in_lo),
    .in_rob1(in_rob1), .in_rob2(in_rob2), .in_pd1(in_pd1), .in_pd2(in_pd2),
    .in_we1(in_we1), .in_we2(in_we2),
    .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi), .out_lo(out_lo),
    .out_rob1(out_rob1), .out_rob2(out_rob2), .out_pd1(out_pd1), .out_pd2(out_pd2),
    .out_we1(out_we1), .out_we2(out_we2), .out_div0(out_div0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] tags_of(input int s);
    logic [31:0] v;
    v = 32'(s);
    return {v[3:0], ~v[3:0], 6'(v * 3), 6'(v + 7), v[0], ~v[0]};
  endfunction

  function automatic logic [TW-1:0] out_tags();
    return {out_rob1, out_rob2, out_pd1, out_pd2, out_we1, out_we2};
  endfunction

  // Reference result {div0, hi, lo} from native 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p, acc;
    if (is_signed_op(op)) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    acc = {hi, lo};
    if (is_div_op(op)) begin
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    p = sa * sb;
    if (op == OP_MADD || op == OP_MADDU) p = acc + p;
    else if (op == OP_MSUB || op == OP_MSUBU) p = acc - p;
    return {1'b0, p};
  endfunction

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, b, hi, lo, input int s);
    logic [TW-1:0] t;
    t = tags_of(s);
    {in_rob1, in_rob2, in_pd1, in_pd2, in_we1, in_we2} = t;
    in_op = op; in_src1 = a; in_src2 = b; in_hi = hi; in_lo = lo;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                       input logic [64:0] exp, input bit push, output int acc_cyc);
    bit got;
    got = 1'b0;
    seq++;
    drive_op(op, a, b, hi, lo, seq);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    check("accept", 64'(got), 64'd1);
    acc_cyc = cyc;
    if (push) exp_q.push_back({exp[64], tags_of(seq), exp[63:0]});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc_cyc, input int lat, input string tag);
    bit got;
    logic [W-1:0] e;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(lat));
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_hilo"}, {out_hi, out_lo}, e[63:0]);
        check({tag, "_tags"}, 64'(out_tags()), 64'(e[64 +: TW]));
        check({tag, "_div0"}, 64'(out_div0), 64'(e[W-1]));
      end
      if (out_ready) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c_ret;
    logic [64:0] ex;
    logic [TW-1:0] t_bp;
    logic [3:0] ops [10];
    logic [3:0] op;
    logic [31:0] a, b, h, l;
    ops = '{OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU, OP_DIV};

    // Clock/reset
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = OP_NONE; in_src1 = '0; in_src2 = '0; in_hi = '0; in_lo = '0;
    in_rob1 = '0; in_rob2 = '0; in_pd1 = '0; in_pd2 = '0; in_we1 = 1'b0; in_we2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_hilo", {out_hi, out_lo}, 64'd0);
    check("rst_tags", 64'(out_tags()), 64'd0);
    check("rst_div0", 64'(out_div0), 64'd0);
    @(posedge clk); #1;

    // Multiply family
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFA}, 1'b1, acc);
    wait_result(acc, MUL_LAT, "mult");
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, {1'b0, 64'h0000_0002_FFFF_FFFA}, 1'b1, acc);
    wait_result(acc, MUL_LAT, "multu");
    issue(OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, {1'b0, 64'h0000_0001_0000_0000}, 1'b1, acc);
    wait_result(acc, MUL_LAT, "madd");
    issue(OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, acc);
    wait_result(acc, MUL_LAT, "msubu");

    // Divide family, including zero divisor and signed overflow
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD}, 1'b1, acc);
    wait_result(acc, DIV_LAT, "div_neg");
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, {1'b0, 64'h8000_0000_0000_0000}, 1'b1, acc);
    wait_result(acc, DIV_LAT, "divu_big");
    issue(OP_DIVU, 32'h0000_1234, 32'd0, 32'd0, 32'd0, {1'b1, 64'h0000_1234_FFFF_FFFF}, 1'b1, acc);
    wait_result(acc, 2, "div0");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, {1'b0, 64'h0000_0000_8000_0000}, 1'b1, acc);
    wait_result(acc, DIV_LAT, "div_ovf");

    // Random mix against the arithmetic model
    for (int k = 0; k < 8; k++) begin
      op = ops[$urandom_range(0, 9)];
      a = $urandom(); h = $urandom(); l = $urandom();
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      if (!is_div_op(op) && b == 32'd0) b = $urandom_range(1, 1000);
      ex = model(op, a, b, h, l);
      issue(op, a, b, h, l, ex, 1'b1, acc);
      wait_result(acc, is_div_op(op) ? ((b == 32'd0) ? 2 : DIV_LAT) : MUL_LAT, "rand");
    end

    // Unknown op codes are ignored
    drive_op(4'hF, 32'd5, 32'd6, 32'd0, 32'd0, 0);
    repeat (3) begin
      @(negedge clk);
      check("ign_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ign_no_result", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Flush during divide iteration 10; MULT offered in the flush cycle then retried
    issue(OP_DIV, 32'd1000, 32'd7, 32'd0, 32'd0, 65'd0, 1'b0, acc);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    drive_op(OP_MULT, 32'hFFFF_FFFB, 32'd7, 32'd0, 32'd0, 99);
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    issue(OP_MULT, 32'hFFFF_FFFB, 32'd7, 32'd0, 32'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFDD}, 1'b1, acc);
    wait_result(acc, MUL_LAT, "post_flush");
    check("flush_sb_empty", 64'(exp_q.size()), 64'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush_no_div_result", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Backpressure: result held for 5 cycles, then retire + accept together
    out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    ex = model(OP_MULTU, a, b, 32'd0, 32'd0);
    issue(OP_MULTU, a, b, 32'd0, 32'd0, ex, 1'b1, acc);
    t_bp = tags_of(seq);
    wait_result(acc, MUL_LAT, "bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hilo", {out_hi, out_lo}, ex[63:0]);
      check("bp_tags", 64'(out_tags()), 64'(t_bp));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    c_ret = cyc;
    a = 32'hDEAD_BEEF; b = 32'h0000_0100; h = 32'h1; l = 32'h2;
    ex = model(OP_MADDU, a, b, h, l);
    issue(OP_MADDU, a, b, h, l, ex, 1'b1, acc);
    check("bb_same_cycle", 64'(acc), 64'(c_ret));
    wait_result(acc, MUL_LAT, "bb");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit for the out-of-order execute stage.
- Accepts one HI/LO-class op per issue handshake.
- Computes MUL/MULT/MULTU/MADD/MADDU/MSUB/MSUBU through a MUL_STAGES-deep pipelined multiplier.
- Computes DIV/DIVU with an in-house iterative divider retiring DIV_BPC quotient bits per cycle.
- Returns a {hi, lo} pair plus two ROB tags to commit; flush aborts any in-flight op with no cancel bookkeeping.

Parameters:
- XLEN, 32: operand width; result is 2*XLEN.
- MUL_STAGES, 3: multiplier latency in cycles (legal 1..6).
- DIV_BPC, 1: quotient bits per divide iteration (1 or 2; XLEN divisible by DIV_BPC).
- ROB_W, 4: ROB entry index width.
- PREG_W, 6: physical register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  pipeline flush; abort current op
- in_valid  in  1  issue offers an op
- in_ready  out  1  unit accepts op this cycle
- in_op  in  4  mdu_op_e operation
- in_src1, in_src2  in  XLEN  multiplicand/dividend, multiplier/divisor
- in_hi, in_lo  in  XLEN  accumulator for MADD/MSUB family
- in_rob1, in_rob2  in  ROB_W  ROB tags (HI-dest, LO-dest)
- in_pd1, in_pd2  in  PREG_W  physical dests
- in_we1, in_we2  in  1  rf write enables
- out_valid  out  1  result available
- out_ready  in  1  commit accepts result
- out_hi, out_lo  out  XLEN  result halves (div: hi=remainder, lo=quotient)
- out_rob1, out_rob2, out_pd1, out_pd2, out_we1, out_we2  out  as input  tags echoed unchanged
- out_div0  out  1  result came from divide-by-zero path

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset: state=IDLE; out_valid=0; out_hi/out_lo=0; all tags/we=0; in_ready=1.
- FSM: IDLE, MUL, DIV, DONE.
  - IDLE: on in_valid, latch operands/tags; mul-family -> MUL, div-family -> DIV; any other op code is ignored and state stays IDLE.
  - MUL: counter runs 1..MUL_STAGES; at MUL_STAGES -> DONE.
  - DIV: iterate; on divider done -> DONE.
  - DONE: out_valid=1; on out_ready -> IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back acceptance is allowed in the same cycle as result retirement.
- Multiply:
  - Signed ops use abs operands; product is negated when sign bits differ.
  - MADD*: {hi,lo}+prod; MSUB*: {hi,lo}-prod; both mod 2^(2*XLEN).
  - Latency in_valid&in_ready -> out_valid = MUL_STAGES+1 cycles.
- Divide:
  - Restoring, on abs values for DIV; XLEN/DIV_BPC iterations; one cycle for sign fixup.
  - Quotient sign = s1^s2; remainder sign = s1.
  - Latency = XLEN/DIV_BPC+2 cycles.
- Divide-by-zero: detected in the first DIV cycle; skip iteration, go to DONE next cycle. Result lo=all ones, hi=in_src1; out_div0=1.
- Signed overflow (min_int / -1): lo=min_int, hi=0; no special path.
- Flush:
  - Highest priority over every state.
  - Next cycle: state=IDLE, out_valid=0, divider/mul counters cleared.
  - An op offered in the flush cycle is not accepted (in_ready forced 0 while flush=1).
- out_* holds stable while out_valid && !out_ready.

Decomposition:
- mdu_pkg holds mdu_op_e, is_mul_op(), is_signed_op(), is_acc_op() helpers, and the state enum.
- Sub-module mdu_divider (XLEN, DIV_BPC):
  - Ports: start/abort/signed_op/dividend/divisor in; busy/done/quotient/remainder/div0 out.
  - Owns the iteration counter and partial remainder.
- Multiplier is behavioural, registered through a MUL_STAGES pipeline for retiming; no sub-module.

Test Plan:
- MULT src1=0xFFFFFFFE, src2=3 -> after 4 cycles out_hi=0xFFFFFFFF, out_lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- MADD hi=0, lo=0xFFFFFFFF, src1=1, src2=1 -> out_hi=1, out_lo=0; MSUBU hi=lo=0, src1=src2=1 -> hi=lo=0xFFFFFFFF.
- DIV src1=-7, src2=2, DIV_BPC=1 -> out_valid exactly 34 cycles after accept; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0x80000000/0xFFFFFFFF -> lo=0, hi=0x80000000.
- DIVU src2=0, src1=0x1234 -> out_valid 2 cycles after accept; lo=0xFFFFFFFF, hi=0x1234, out_div0=1; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Flush at divide iteration 10 with a new MULT offered the next cycle -> no result for the divide; the MULT result is correct and the tags are the MULT's.
- out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; at out_ready=1 with in_valid=1 the next op is accepted the same cycle.
